micro_ucr_miner_ctrl: RTL and testbench

MICRO_UCR_MINER_CTRL -- requirements
Module: micro_ucr_miner_ctrl

---
 rtl/micro_ucr_pkg.sv | 25 ++
 rtl/micro_ucr_target_cmp.sv | 20 ++
 rtl/micro_ucr_miner_ctrl.sv | 136 +++++++++++++
 tb/tb_micro_ucr_miner_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_ucr_pkg.sv
// rtl/micro_ucr_pkg.sv - shared types and constants for the micro_ucr miner controller
// Holds the controller state enum, engine round limit, datapath widths and
// the hash engine init vector shared with the surrounding integration.
package micro_ucr_pkg;

    localparam int NONCE_W   = 32;
    localparam int PAYLOAD_W = 96;
    localparam int HASH_W    = 24;
    localparam int BLOCK_W   = PAYLOAD_W + NONCE_W;

    // Engine counts 0..HASH_LAST_ROUND; its result is valid one cycle later.
    localparam logic [5:0] HASH_LAST_ROUND = 6'd34;

    localparam logic [HASH_W-1:0] HASH_INIT = 24'hFE8901;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_WAIT,
        ST_CHECK,
        ST_FOUND,
        ST_EXHAUST
    } miner_state_t;

endpackage

// File: rtl/micro_ucr_target_cmp.sv
// rtl/micro_ucr_target_cmp.sv - difficulty comparison of an engine hash against the target
// Ports:
//   hash_H  in   engine hash result
//   target  in   difficulty threshold
//   hit     out  both upper hash bytes are strictly below target (unsigned)
module micro_ucr_target_cmp
    import micro_ucr_pkg::*;
(
    input  logic [HASH_W-1:0] hash_H,
    input  logic [7:0]        target,
    output logic              hit
);

    // The low hash byte does not take part in the difficulty test.
    logic unused_low_byte;
    assign unused_low_byte = ^hash_H[7:0];

    assign hit = (hash_H[23:16] < target) && (hash_H[15:8] < target);

endmodule

// File: rtl/micro_ucr_miner_ctrl.sv
// rtl/micro_ucr_miner_ctrl.sv - nonce search controller driving the micro_ucr hash engine
// Feeds the engine {payload, nonce} blocks, one per 35-cycle engine pass, and
// stops at the first nonce whose hash clears the target or at NONCE_LIMIT.
// Optional feature macro: MINER_STATS_EN adds the saturating 'attempts' output.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               search request, accepted in IDLE, FOUND or EXHAUST
//   payload, target     header bits and difficulty, latched on accepted start
//   hash_count, hash_H  engine round counter and hash result
//   bloque_out, fin_out block and fin strobe to the engine
//   busy, found, exhausted  search status
//   nonce_out, hash_out winning nonce and hash, valid while found=1
//   attempts            CHECK cycles since last start (MINER_STATS_EN only)
module micro_ucr_miner_ctrl
    import micro_ucr_pkg::*;
#(
    parameter logic [31:0] NONCE_START = 32'h0000_0000,
    parameter logic [31:0] NONCE_LIMIT = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [7:0]           target,
    input  logic [5:0]           hash_count,
    input  logic [HASH_W-1:0]    hash_H,
    output logic [BLOCK_W-1:0]   bloque_out,
    output logic                 fin_out,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [NONCE_W-1:0]   nonce_out,
    output logic [HASH_W-1:0]    hash_out
`ifdef MINER_STATS_EN
    ,
    output logic [31:0]          attempts
`endif
);

    miner_state_t state;
    logic [7:0]   target_q;
    logic         hit;
    logic         start_accept;

    // The nonce under test lives in the low word of the block register, so
    // the engine always sees exactly what is being checked.
    logic [NONCE_W-1:0] nonce;
    assign nonce = bloque_out[NONCE_W-1:0];

    assign start_accept = start &&
                          ((state == ST_IDLE) || (state == ST_FOUND) || (state == ST_EXHAUST));

    micro_ucr_target_cmp u_cmp (
        .hash_H (hash_H),
        .target (target_q),
        .hit    (hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bloque_out <= '0;
            fin_out    <= 1'b1;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            nonce_out  <= '0;
            hash_out   <= '0;
            target_q   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FOUND, ST_EXHAUST: begin
                    if (start_accept) begin
                        bloque_out <= {payload, NONCE_START};
                        target_q   <= target;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        busy       <= 1'b1;
                        fin_out    <= 1'b0;
                        state      <= ST_SYNC;
                    end
                end
                // Align to the start of an engine pass so the new block is
                // stable when the engine samples it on counts 1 and 2.
                ST_SYNC: begin
                    if (hash_count == 6'd0) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (hash_count == HASH_LAST_ROUND) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        nonce_out <= nonce;
                        hash_out  <= hash_H;
                        found     <= 1'b1;
                        busy      <= 1'b0;
                        fin_out   <= 1'b1;
                        state     <= ST_FOUND;
                    end else if (nonce == NONCE_LIMIT) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        fin_out   <= 1'b1;
                        state     <= ST_EXHAUST;
                    end else begin
                        // The engine wraps to count 0 during CHECK, so going
                        // straight back to WAIT keeps the 35-cycle cadence.
                        bloque_out[NONCE_W-1:0] <= nonce + 32'd1;
                        state                   <= ST_WAIT;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    fin_out <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MINER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attempts <= '0;
        end else if (start_accept) begin
            attempts <= '0;
        end else if ((state == ST_CHECK) && (attempts != 32'hFFFF_FFFF)) begin
            attempts <= attempts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_micro_ucr_miner_ctrl.sv
// tb/tb_micro_ucr_miner_ctrl.sv - scoreboard bench for micro_ucr_miner_ctrl with behavioural hash engines
module tb_micro_ucr_miner_ctrl;
    import micro_ucr_pkg::*;

    typedef struct packed {
        logic        fnd;
        logic [31:0] nonce;
        logic [23:0] hash;
        logic [31:0] nchk;
    } exp_t;

    localparam logic [31:0] START_B = 32'd5;
    localparam logic [31:0] LIMIT_B = 32'd7;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         start_s [2];
    logic [95:0]  pay_s   [2];
    logic [7:0]   tgt_s   [2];
    logic [127:0] blq     [2];
    logic         fin     [2];
    logic         busy    [2];
    logic         fnd     [2];
    logic         exh     [2];
    logic [31:0]  nout    [2];
    logic [23:0]  hout    [2];
`ifdef MINER_STATS_EN
    logic [31:0]  att     [2];
`endif

    int checks = 0;
    int errors = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];

    task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h, expected %0h", d, name, act, expv);
        end
    endtask

    // Stand-in for the engine's digest: any fixed mixing of the block works,
    // as long as the reference model and the engine model share it.
    function automatic logic [23:0] hashf(input logic [127:0] b);
        logic [23:0] h;
        h = HASH_INIT;
        for (int i = 0; i < 16; i++) begin
            h = (h ^ {16'd0, b[i*8 +: 8]}) * 24'h000193;
            h = h ^ (h >> 9);
        end
        return h;
    endfunction

    // Linear search over nonces s..l; nchk==0 means unresolved within cap.
    function automatic exp_t model(input logic [95:0] p, input logic [7:0] t,
                                   input logic [31:0] s, input logic [31:0] l, input int cap);
        exp_t e;
        logic [31:0] n;
        logic [23:0] h;
        e = '0;
        n = s;
        for (int i = 0; i < cap; i++) begin
            h = hashf({p, n});
            if (h[23:16] < t && h[15:8] < t) begin
                e.fnd = 1'b1; e.nonce = n; e.hash = h; e.nchk = 32'(i + 1);
                return e;
            end
            if (n == l) begin
                e.nchk = 32'(i + 1);
                return e;
            end
            n = n + 32'd1;
        end
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gm
        logic [5:0]   hc;
        logic [23:0]  hh;
        logic [127:0] eblk;
        int           since;
        int           nchk;
        logic         active;
        logic         held_valid;
        logic [31:0]  pn;
        logic [127:0] held_blq;
        logic [1:0]   held_st;
        exp_t         e;
        logic         got;

        micro_ucr_miner_ctrl #(
            .NONCE_START(g == 0 ? 32'd0 : START_B),
            .NONCE_LIMIT(g == 0 ? 32'hFFFF_FFFF : LIMIT_B)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start_s[g]),
            .payload    (pay_s[g]),
            .target     (tgt_s[g]),
            .hash_count (hc),
            .hash_H     (hh),
            .bloque_out (blq[g]),
            .fin_out    (fin[g]),
            .busy       (busy[g]),
            .found      (fnd[g]),
            .exhausted  (exh[g]),
            .nonce_out  (nout[g]),
            .hash_out   (hout[g])
`ifdef MINER_STATS_EN
            ,
            .attempts   (att[g])
`endif
        );

        // Engine 0 parks at count 0 while fin=1; engine 1 free-runs so the
        // controller has to synchronise to an arbitrary phase.
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                hc   <= 6'd0;
                hh   <= 24'd0;
                eblk <= 128'd0;
            end else begin
                if (g == 0 && fin[g]) hc <= 6'd0;
                else if (hc == HASH_LAST_ROUND) hc <= 6'd0;
                else hc <= hc + 6'd1;
                if (hc == 6'd1) eblk <= blq[g];
                if (hc == HASH_LAST_ROUND) hh <= hashf(eblk);
            end
        end

        task automatic chk_gap();
            if (nchk == 1) chk("first_check_within_71", g, 128'(since <= 72), 128'(1));
            else           chk("cycles_between_checks", g, 128'(since), 128'(35));
        endtask

        // A check is visible as a nonce step while busy, or as the drop of busy.
        always @(negedge clk) begin
            if (reset) begin
                active     = 1'b0;
                held_valid = 1'b0;
            end else begin
                chk("fin_out", g, 128'(fin[g]), 128'(!busy[g]));
                if (!active && busy[g]) begin
                    active     = 1'b1;
                    held_valid = 1'b0;
                    since      = 0;
                    nchk       = 0;
                    pn         = blq[g][31:0];
                end else if (active) begin
                    since++;
                    if (busy[g] && blq[g][31:0] != pn) begin
                        nchk++;
                        pn = blq[g][31:0];
                        chk_gap();
                        since = 0;
                    end else if (!busy[g]) begin
                        nchk++;
                        active = 1'b0;
                        chk_gap();
                        got = 1'b0;
                        if (g == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); got = 1'b1; end
                        if (g == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); got = 1'b1; end
                        if (!got) begin
                            chk("unexpected_result", g, 128'(1), 128'(0));
                        end else begin
                            chk("found", g, 128'(fnd[g]), 128'(e.fnd));
                            chk("exhausted", g, 128'(exh[g]), 128'(!e.fnd));
                            chk("num_checks", g, 128'(nchk), 128'(e.nchk));
                            if (e.fnd) begin
                                chk("nonce_out", g, 128'(nout[g]), 128'(e.nonce));
                                chk("hash_out", g, 128'(hout[g]), 128'(e.hash));
                            end
`ifdef MINER_STATS_EN
                            chk("attempts", g, 128'(att[g]), 128'(e.nchk));
`endif
                        end
                        held_blq   = blq[g];
                        held_st    = {fnd[g], exh[g]};
                        held_valid = 1'b1;
                    end
                end else if (held_valid) begin
                    chk("result_hold_block", g, blq[g], held_blq);
                    chk("result_hold_status", g, 128'({fnd[g], exh[g]}), 128'(held_st));
                end
            end
        end
    end

    task automatic chk_reset(input int d);
        chk("rst_bloque_out", d, blq[d], 128'd0);
        chk("rst_fin_out", d, 128'(fin[d]), 128'(1));
        chk("rst_busy", d, 128'(busy[d]), 128'(0));
        chk("rst_found", d, 128'(fnd[d]), 128'(0));
        chk("rst_exhausted", d, 128'(exh[d]), 128'(0));
        chk("rst_nonce_out", d, 128'(nout[d]), 128'(0));
        chk("rst_hash_out", d, 128'(hout[d]), 128'(0));
    endtask

    task automatic pick(input logic [7:0] t, input int kmin, input int kmax, output logic [95:0] p);
        exp_t e;
        p = 96'd0;
        for (int i = 0; i < 20000; i++) begin
            p = {$urandom, $urandom, $urandom};
            e = model(p, t, 32'd0, 32'hFFFF_FFFF, kmax);
            if (e.fnd && e.nonce >= 32'(kmin)) return;
        end
    endtask

    task automatic run(input int d, input logic [95:0] p, input logic [7:0] t, input bit poke);
        exp_t e;
        int   budget;
        if (d == 0) e = model(p, t, 32'd0, 32'hFFFF_FFFF, 64);
        else        e = model(p, t, START_B, LIMIT_B, 64);
        repeat ($urandom_range(0, 37)) @(negedge clk);
        pay_s[d]   = p;
        tgt_s[d]   = t;
        start_s[d] = 1'b1;
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
        @(negedge clk);
        start_s[d] = 1'b0;
        chk("start_sets_busy", d, 128'(busy[d]), 128'(1));
        chk("start_clears_found", d, 128'(fnd[d]), 128'(0));
        chk("start_clears_exhausted", d, 128'(exh[d]), 128'(0));
        if (poke && e.nchk >= 32'd3) begin
            repeat (40) @(negedge clk);
            pay_s[d]   = {$urandom, $urandom, $urandom};
            tgt_s[d]   = 8'hFF;
            start_s[d] = 1'b1;
            @(negedge clk);
            start_s[d] = 1'b0;
            chk("busy_after_ignored_start", d, 128'(busy[d]), 128'(1));
        end
        budget = int'(e.nchk) * 35 + 100;
        while (busy[d] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("search_completes", d, 128'(budget > 0), 128'(1));
        @(negedge clk);
    endtask

    initial begin
        logic [95:0] p42;
        logic [95:0] p;
        int          budget;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            pay_s[d]   = 96'd0;
            tgt_s[d]   = 8'd0;
        end
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        reset = 1'b0;

        run(0, 96'd0, 8'hFF, 1'b0);
        run(1, {$urandom, $urandom, $urandom}, 8'h00, 1'b0);

        pick(8'h10, 2, 12, p42);
        run(0, p42, 8'h10, 1'b1);

        // Abort mid-search at engine count 20, then repeat the same search.
        pay_s[0]   = p42;
        tgt_s[0]   = 8'h10;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        budget = 200;
        while (!(busy[0] && gm[0].hc == 6'd20) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reached_wait_count20", 0, 128'(budget > 0), 128'(1));
        #2 reset = 1'b1;
        #1 chk_reset(0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run(0, p42, 8'h10, 1'b0);

        for (int i = 0; i < 5; i++) begin
            pick(8'($urandom_range(48, 255)), 0, 20, p);
            run(0, p, 8'($urandom_range(48, 255)) | 8'h30, i[0]);
            run(1, {$urandom, $urandom, $urandom}, 8'($urandom_range(0, 255)), i[0]);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
